// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480 timing constants, derived totals and state type
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;   // 800
  localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;                           // 656
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;                     // 751

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;   // 525
  localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;                           // 490
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;                     // 491

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Pin level for a raw sync: pol=1 drives the active phase high, pol=0 low.
  function automatic logic sync_pin(input logic raw_active, input logic pol);
    return ~(raw_active ^ pol);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with IDLE/RUN/DRAIN control
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        enable,
  input  logic        hsync_pol,
  input  logic        vsync_pol,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        running
);

  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  state_t      state, state_n;
  logic        started, started_n;
  logic [10:0] h_n, v_n;
  logic        fs_n;
  logic        at_last;
  logic        frame_wrap;
  logic        vis_n;

  // started marks that (0,0) has been presented; until then a fresh RUN holds at origin.
  assign at_last    = started && (hcount == H_LAST) && (vcount == V_LAST);
  assign frame_wrap = pix_ce && at_last;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (enable) state_n = ST_RUN;
      ST_RUN:   if (!enable) state_n = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)                  state_n = ST_RUN;
        else if (pix_ce && at_last)  state_n = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  // Counting is driven by the next state so a coinciding pix_ce sees the new mode.
  always_comb begin
    h_n       = hcount;
    v_n       = vcount;
    started_n = started;
    fs_n      = 1'b0;
    if (state_n == ST_IDLE) begin
      h_n       = 11'd0;
      v_n       = 11'd0;
      started_n = 1'b0;
    end else if (pix_ce) begin
      if (!started) begin
        h_n       = 11'd0;
        v_n       = 11'd0;
        started_n = 1'b1;
        fs_n      = 1'b1;
      end else if (hcount == H_LAST) begin
        h_n = 11'd0;
        if (vcount == V_LAST) begin
          v_n  = 11'd0;
          fs_n = 1'b1;
        end else begin
          v_n = vcount + 11'd1;
        end
      end else begin
        h_n = hcount + 11'd1;
      end
    end
  end

  assign vis_n = (state_n != ST_IDLE) && started_n;

  // Decode from the next counter values so syncs/blanks land with their counters.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      started     <= 1'b0;
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
      hblnk       <= 1'b1;
      vblnk       <= 1'b1;
      hsync       <= sync_pin(1'b0, hsync_pol);
      vsync       <= sync_pin(1'b0, vsync_pol);
    end else begin
      state       <= state_n;
      started     <= started_n;
      hcount      <= h_n;
      vcount      <= v_n;
      frame_start <= fs_n;
      if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
      hblnk       <= !vis_n || (h_n >= H_VIS);
      vblnk       <= !vis_n || (v_n >= V_VIS);
      hsync       <= sync_pin(vis_n && (h_n >= HS_START) && (h_n <= HS_END), hsync_pol);
      vsync       <= sync_pin(vis_n && (v_n >= VS_START) && (v_n <= VS_END), vsync_pol);
    end
  end

  assign running = (state != ST_IDLE);

endmodule
